// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, start/stop validation and an acknowledge-held byte.
// The divisor for the rate select is captured at start detect, so rate changes only affect later frames.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned OVS      = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] baud_rate,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned Div2400  = (CLK_FREQ + 8 * 2400) / (16 * 2400);
   localparam int unsigned Div4800  = (CLK_FREQ + 8 * 4800) / (16 * 4800);
   localparam int unsigned Div9600  = (CLK_FREQ + 8 * 9600) / (16 * 9600);
   localparam int unsigned Div19200 = (CLK_FREQ + 8 * 19200) / (16 * 19200);
   localparam logic [3:0]  SampMid  = 4'(OVS / 2 - 1);
   localparam logic [3:0]  SampLast = 4'(OVS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [1:0]  r_sync;
   logic [15:0] r_div;
   logic [15:0] r_tick_cnt;
   logic [3:0]  r_samp_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_fe;
   logic        r_ovr;

   logic [15:0] w_div_sel;
   logic        w_rx_s;
   logic        w_tick;
   logic        w_start;
   logic        w_go_data;
   logic        w_shift_en;
   logic        w_stop_ok;
   logic        w_stop_bad;

   assign w_rx_s = r_sync[1];
   assign w_tick = (r_tick_cnt == r_div - 16'd1);

   always_comb begin
      w_div_sel = 16'(Div2400);
      unique case (baud_rate)
         2'b00: w_div_sel = 16'(Div2400);
         2'b01: w_div_sel = 16'(Div4800);
         2'b10: w_div_sel = 16'(Div9600);
         2'b11: w_div_sel = 16'(Div19200);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_sync  <= 2'b11;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= {r_sync[0], rx};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_go_data   = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         StIdle: begin
            if (!w_rx_s) begin
               w_state_nxt = StStart;
               w_start     = 1'b1;
            end
         end
         StStart: begin
            // A line that is high again at mid start bit was a glitch.
            if (w_tick && r_samp_cnt == SampMid) begin
               if (w_rx_s) begin
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt = StData;
                  w_go_data   = 1'b1;
               end
            end
         end
         StData: begin
            if (w_tick && r_samp_cnt == SampLast) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 3'd7) w_state_nxt = StStop;
            end
         end
         StStop: begin
            if (w_tick && r_samp_cnt == SampLast) begin
               if (w_rx_s) begin
                  w_stop_ok   = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_stop_bad  = 1'b1;
                  w_state_nxt = StBreak;
               end
            end
         end
         StBreak: begin
            if (w_rx_s) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div      <= 16'(Div2400);
         r_tick_cnt <= 16'd0;
         r_samp_cnt <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'd0;
      end else begin
         if (w_start) r_div <= w_div_sel;
         if (w_start || w_tick) r_tick_cnt <= 16'd0;
         else                   r_tick_cnt <= r_tick_cnt + 16'd1;
         if (w_start || w_go_data) r_samp_cnt <= 4'd0;
         else if (w_tick)          r_samp_cnt <= r_samp_cnt + 4'd1;
         if (w_start)         r_bit_cnt <= 3'd0;
         else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
         if (w_shift_en) r_shift[r_bit_cnt] <= w_rx_s;
      end
   end

   // A delivery coinciding with rx_ack replaces the held byte instead of overrunning.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= 8'd0;
         r_valid <= 1'b0;
         r_fe    <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_fe  <= w_stop_bad;
         r_ovr <= w_stop_ok && r_valid && !rx_ack;
         if (w_stop_ok && (!r_valid || rx_ack)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (rx_ack) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_fe;
   assign overrun   = r_ovr;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_FREQ=1 MHz: divisors 26/13/7/3 for rate codes 00..11.
// Table-driven frames with auto-acknowledge, plus sequences for error, glitch, overrun and reset.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] baud_rate = 2'b10;
   logic       rx = 1'b1;
   logic       ack_man = 1'b0;
   logic       ack_auto = 1'b0;
   logic       auto_ack = 1'b0;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int rise_cyc = -1;
   int fe_cnt = 0;
   int ovr_cnt = 0;
   int both_cnt = 0;
   logic valid_prev = 1'b0;
   logic [7:0] got_q[$];

   assign rx_ack = ack_man | ack_auto;

   uart_rx #(.CLK_FREQ(1_000_000), .OVS(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_rate (baud_rate),
      .rx        (rx),
      .rx_ack    (rx_ack),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) ovr_cnt = ovr_cnt + 1;
      if (frame_err && overrun) both_cnt = both_cnt + 1;
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rx_valid;
      if (auto_ack && rx_valid && !ack_auto) begin
         got_q.push_back(rx_data);
         ack_auto = 1'b1;
      end else begin
         ack_auto = 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start bit is driven 1 time unit after edge P0; t0 holds the cycle count at P0.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
      @(posedge clk);
      #1;
      t0 = cyc;
      rx = 1'b0;
      repeat (16 * div) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (16 * div) @(posedge clk);
         #1;
      end
      rx = stop;
      repeat (16 * div) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      @(posedge clk);
      #1 ack_man = 1'b1;
      @(posedge clk);
      #1 ack_man = 1'b0;
   endtask

   typedef struct {
      logic [1:0] rate;
      int         div;
      logic [7:0] data;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // Latency = 2 sync + 1 start-detect + 152 ticks of the latched divisor.
      vecs[0] = '{2'b10, 7,  8'hA5, 1067};
      vecs[1] = '{2'b00, 26, 8'h3C, 3955};
      vecs[2] = '{2'b00, 26, 8'hC3, 3955};
      vecs[3] = '{2'b01, 13, 8'h3C, 1979};
      vecs[4] = '{2'b01, 13, 8'hC3, 1979};
      vecs[5] = '{2'b10, 7,  8'h3C, 1067};
      vecs[6] = '{2'b10, 7,  8'hC3, 1067};
      vecs[7] = '{2'b11, 3,  8'h3C, 459};
      vecs[8] = '{2'b11, 3,  8'hC3, 459};

      #1;
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (5) @(posedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      auto_ack = 1'b1;
      for (int v = 0; v < 9; v++) begin
         baud_rate = vecs[v].rate;
         send_frame(vecs[v].data, 1'b1, vecs[v].div);
         check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) check($sformatf("vec%0d_data", v), 32'(got_q.pop_front()), 32'(vecs[v].data));
         check($sformatf("vec%0d_latency", v), 32'(rise_cyc - t0), 32'(vecs[v].lat));
      end
      auto_ack = 1'b0;
      repeat (3) @(posedge clk);
      check("vec_frame_err_none", 32'(fe_cnt), 32'd0);
      check("vec_overrun_none", 32'(ovr_cnt), 32'd0);
      check("vec_valid_cleared", 32'(rx_valid), 32'd0);

      // Held byte and single-cycle acknowledge.
      baud_rate = 2'b10;
      send_frame(8'hA5, 1'b1, 7);
      check("a5_valid", 32'(rx_valid), 32'd1);
      check("a5_data", 32'(rx_data), 32'hA5);
      @(posedge clk);
      #1 ack_man = 1'b1;
      check("ack_not_comb", 32'(rx_valid), 32'd1);
      @(posedge clk);
      #1 ack_man = 1'b0;
      check("ack_clears", 32'(rx_valid), 32'd0);
      check("ack_keeps_data", 32'(rx_data), 32'hA5);

      // Bad stop bit, then the line held low for two frame times.
      fe_cnt = 0;
      send_frame(8'h55, 1'b0, 7);
      check("fe_pulse", 32'(fe_cnt), 32'd1);
      check("fe_no_valid", 32'(rx_valid), 32'd0);
      check("fe_break_busy", 32'(busy), 32'd1);
      repeat (2 * 160 * 7) @(posedge clk);
      #1;
      check("break_no_refire", 32'(fe_cnt), 32'd1);
      check("break_still_busy", 32'(busy), 32'd1);
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("break_exit_idle", 32'(busy), 32'd0);

      // Start-bit glitch of 4 ticks.
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("glitch_busy", 32'(busy), 32'd1);
      repeat (18) @(posedge clk);
      #1 rx = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(rx_valid), 32'd0);
      check("glitch_no_fe", 32'(fe_cnt), 32'd1);
      send_frame(8'h81, 1'b1, 7);
      check("post_glitch_valid", 32'(rx_valid), 32'd1);
      check("post_glitch_data", 32'(rx_data), 32'h81);
      ack_pulse();

      // Overrun, then delivery coinciding with acknowledge.
      ovr_cnt = 0;
      send_frame(8'h11, 1'b1, 7);
      check("ovr_first_data", 32'(rx_data), 32'h11);
      send_frame(8'h22, 1'b1, 7);
      check("ovr_pulse", 32'(ovr_cnt), 32'd1);
      check("ovr_data_kept", 32'(rx_data), 32'h11);
      check("ovr_valid_kept", 32'(rx_valid), 32'd1);
      fork
         send_frame(8'h22, 1'b1, 7);
         begin
            @(posedge clk);
            repeat (2 + 152 * 7) @(posedge clk);
            #1 ack_man = 1'b1;
            @(posedge clk);
            #1 ack_man = 1'b0;
            check("ackdel_data", 32'(rx_data), 32'h22);
            check("ackdel_valid", 32'(rx_valid), 32'd1);
         end
      join
      check("ackdel_no_ovr", 32'(ovr_cnt), 32'd1);
      check("no_fe_ovr_overlap", 32'(both_cnt), 32'd0);

      // Reset in the middle of data bit 4 of 0xF0 while 0x22 is still held.
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (16 * 7 * 5) @(posedge clk);
      #1 rx = 1'b1;
      repeat (8 * 7) @(posedge clk);
      #1;
      check("pre_reset_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      fork
         send_frame(8'h0F, 1'b1, 7);
         begin
            repeat (500) @(posedge clk);
            #1 baud_rate = 2'b00;
         end
      join
      check("after_rst_valid", 32'(rx_valid), 32'd1);
      check("after_rst_data", 32'(rx_data), 32'h0F);
      ack_pulse();
      send_frame(8'h5A, 1'b1, 26);
      check("new_rate_valid", 32'(rx_valid), 32'd1);
      check("new_rate_data", 32'(rx_data), 32'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
